clock_step_control: RTL and testbench

// Sits between the raw board clock and the pipeline. Divides clock_in by a

---
 rtl/clock_step_control.sv | 139 +++++++++++++
 tb/tb_clock_step_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_control.sv
`default_nettype none
// =============================================================================
// Module   : clock_step_control
// Brief    : Programmable clock divider with run/halt/single-step control.
//            Optional cycle counter enabled by CLOCK_STEP_CYCLE_COUNT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module clock_step_control #(
   parameter int DIV_WIDTH   = 6,
   parameter int DIV_DEFAULT = 2,
   parameter int CYC_WIDTH   = 32
) (
   input  logic                 clock_in,
   input  logic                 reset_n,
   input  logic [DIV_WIDTH-1:0] div_ratio,
   input  logic                 div_load,
   input  logic                 run,
   input  logic                 halt,
   input  logic                 step_req,
   output logic                 step_ack,
   output logic                 clock_out,
   output logic                 clock_en,
   output logic [CYC_WIDTH-1:0] cycle_count,
   output logic [1:0]           state_out
);

   typedef enum logic [1:0] {
      S_HALT  = 2'b00,
      S_RUN   = 2'b01,
      S_STEP  = 2'b10,
      S_DRAIN = 2'b11
   } state_t;

   localparam logic [DIV_WIDTH-1:0] C_RATIO_RESET = DIV_WIDTH'(DIV_DEFAULT);
   localparam logic [DIV_WIDTH-1:0] C_ONE         = DIV_WIDTH'(1);

   state_t               r_state;
   state_t               w_state_next;
   logic [DIV_WIDTH-1:0] r_div_cnt;
   logic [DIV_WIDTH-1:0] r_ratio_reg;
   logic [DIV_WIDTH-1:0] r_ratio_pend;
   logic                 r_clock_out;
   logic                 r_clock_en;
   logic                 r_step_ack;
   logic                 w_active;
   logic                 w_wrap;
   logic                 w_fall;
   logic                 w_rise;

   assign w_active = (r_state != S_HALT);
   assign w_wrap   = w_active && (r_div_cnt == r_ratio_reg - C_ONE);
   assign w_fall   = w_wrap && r_clock_out;
   // A rise is suppressed when this edge parks the clock, so no runt high phase escapes
   assign w_rise   = w_wrap && !r_clock_out && (w_state_next != S_HALT);

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_HALT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_HALT: begin
            if (halt)          w_state_next = S_HALT;
            else if (run)      w_state_next = S_RUN;
            else if (step_req) w_state_next = S_STEP;
         end
         S_RUN: begin
            if (halt || !run) begin
               w_state_next = (!r_clock_out && (r_div_cnt == '0)) ? S_HALT : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_fall) w_state_next = S_HALT;
         end
         S_STEP: begin
            if (w_fall) w_state_next = S_HALT;
         end
         default: w_state_next = S_HALT;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_div_cnt    <= '0;
         r_ratio_reg  <= C_RATIO_RESET;
         r_ratio_pend <= C_RATIO_RESET;
         r_clock_out  <= 1'b0;
         r_clock_en   <= 1'b0;
         r_step_ack   <= 1'b0;
      end else begin
         if (div_load) begin
            r_ratio_pend <= (div_ratio == '0) ? C_ONE : div_ratio;
         end
         // A halted clock sits on a phase boundary, so the pending ratio may apply
         if (w_wrap || !w_active) begin
            r_ratio_reg <= r_ratio_pend;
         end
         r_clock_en <= w_rise;
         r_step_ack <= (r_state == S_STEP) && w_fall;
         if (w_state_next == S_HALT) begin
            r_div_cnt   <= '0;
            r_clock_out <= 1'b0;
         end else if (w_wrap) begin
            r_div_cnt   <= '0;
            r_clock_out <= ~r_clock_out;
         end else if (w_active) begin
            r_div_cnt   <= r_div_cnt + C_ONE;
         end
      end
   end

`ifdef CLOCK_STEP_CYCLE_COUNT_EN
   logic [CYC_WIDTH-1:0] r_cycle_count;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_cycle_count <= '0;
      end else if (w_rise) begin
         r_cycle_count <= r_cycle_count + CYC_WIDTH'(1);
      end
   end

   assign cycle_count = r_cycle_count;
`else
   assign cycle_count = '0;
`endif

   assign clock_out = r_clock_out;
   assign clock_en  = r_clock_en;
   assign step_ack  = r_step_ack;
   assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clock_step_control.sv
`default_nettype none
// =============================================================================
// Module   : tb_clock_step_control
// Brief    : Directed scoreboard bench for clock_step_control.
// Revision : 1.0 - initial release
// =============================================================================
module tb_clock_step_control;

   localparam int DIV_WIDTH = 6;
   localparam int CYC_WIDTH = 32;
`ifdef CLOCK_STEP_CYCLE_COUNT_EN
   localparam bit CC_EN = 1'b1;
`else
   localparam bit CC_EN = 1'b0;
`endif

   logic                 clock_in = 1'b0;
   logic                 reset_n  = 1'b0;
   logic [DIV_WIDTH-1:0] div_ratio = '0;
   logic                 div_load = 1'b0;
   logic                 run      = 1'b0;
   logic                 halt     = 1'b0;
   logic                 step_req = 1'b0;
   logic                 step_ack;
   logic                 clock_out;
   logic                 clock_en;
   logic [CYC_WIDTH-1:0] cycle_count;
   logic [1:0]           state_out;

   always #5 clock_in = ~clock_in;

   clock_step_control #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DIV_DEFAULT (2),
      .CYC_WIDTH   (CYC_WIDTH)
   ) dut (
      .clock_in    (clock_in),
      .reset_n     (reset_n),
      .div_ratio   (div_ratio),
      .div_load    (div_load),
      .run         (run),
      .halt        (halt),
      .step_req    (step_req),
      .step_ack    (step_ack),
      .clock_out   (clock_out),
      .clock_en    (clock_en),
      .cycle_count (cycle_count),
      .state_out   (state_out)
   );

   // Expected per-cycle view: {clock_out, clock_en, state_out, step_ack}
   typedef struct packed {
      logic       co;
      logic       en;
      logic [1:0] st;
      logic       ack;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   task automatic push(input int n, input logic co, input logic en,
                       input logic [1:0] st, input logic ack);
      for (int i = 0; i < n; i++) exp_q.push_back({co, en, st, ack});
   endtask

   task automatic pop_check(input string tag, input int n);
      obs_t       e;
      logic [4:0] a;
      for (int i = 0; i < n; i++) begin
         tick();
         if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            a = {clock_out, clock_en, state_out, step_ack};
            check(tag, {27'd0, a}, {27'd0, e});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) tick();
      check("reset_outputs", {27'd0, clock_out, clock_en, state_out, step_ack}, 32'd0);
      check("reset_cycle_count", cycle_count, 32'd0);
      reset_n = 1'b1;
      tick();

      // Ratio 2 continuous run: 0,0,1,1,0,0,1,1...
      run = 1'b1;
      push(2, 0, 0, 2'b01, 0); push(1, 1, 1, 2'b01, 0); push(1, 1, 0, 2'b01, 0);
      push(2, 0, 0, 2'b01, 0); push(1, 1, 1, 2'b01, 0); push(1, 1, 0, 2'b01, 0);
      push(2, 0, 0, 2'b01, 0); push(1, 1, 1, 2'b01, 0);
      pop_check("run_ratio2", 11);

      // Halt one cycle after a rise: drain the high phase, then park low
      halt = 1'b1;
      push(1, 1, 0, 2'b11, 0); push(4, 0, 0, 2'b00, 0);
      pop_check("halt_drain", 5);
      halt = 1'b0; run = 1'b0;
      push(1, 0, 0, 2'b00, 0);
      pop_check("halt_idle", 1);
      check("cc_after_run", cycle_count, CC_EN ? 32'd3 : 32'd0);

      // Ratio change mid-high phase: current high stays 2, later phases are 5
      run = 1'b1;
      push(2, 0, 0, 2'b01, 0); push(1, 1, 1, 2'b01, 0);
      pop_check("reload_pre", 3);
      div_ratio = 6'd5; div_load = 1'b1;
      push(1, 1, 0, 2'b01, 0);
      pop_check("reload_load", 1);
      div_load = 1'b0;
      push(5, 0, 0, 2'b01, 0); push(1, 1, 1, 2'b01, 0); push(4, 1, 0, 2'b01, 0);
      push(1, 0, 0, 2'b01, 0);
      pop_check("reload_ratio5", 11);
      run = 1'b0;
      push(2, 0, 0, 2'b00, 0);
      pop_check("run_stop", 2);
      check("cc_after_reload", cycle_count, CC_EN ? 32'd5 : 32'd0);

      // Single step at ratio 3
      div_ratio = 6'd3; div_load = 1'b1;
      tick();
      div_load = 1'b0;
      tick();
      step_req = 1'b1;
      push(1, 0, 0, 2'b10, 0);
      pop_check("step3_entry", 1);
      step_req = 1'b0;
      push(2, 0, 0, 2'b10, 0); push(1, 1, 1, 2'b10, 0); push(2, 1, 0, 2'b10, 0);
      push(1, 0, 0, 2'b00, 1); push(2, 0, 0, 2'b00, 0);
      pop_check("step3", 8);
      check("cc_after_step3", cycle_count, CC_EN ? 32'd6 : 32'd0);

      // Ratio 0 behaves as 1; requests during STEP are ignored
      div_ratio = 6'd0; div_load = 1'b1;
      tick();
      div_load = 1'b0;
      tick();
      step_req = 1'b1;
      push(1, 0, 0, 2'b10, 0);
      pop_check("step1_entry", 1);
      halt = 1'b1; run = 1'b1;
      push(1, 1, 1, 2'b10, 0);
      pop_check("step1_rise", 1);
      step_req = 1'b0;
      push(1, 0, 0, 2'b00, 1); push(2, 0, 0, 2'b00, 0);
      pop_check("step1_done", 3);
      halt = 1'b0; run = 1'b0;
      push(1, 0, 0, 2'b00, 0);
      pop_check("step1_idle", 1);
      check("cc_after_step1", cycle_count, CC_EN ? 32'd7 : 32'd0);

      // Asynchronous reset in the middle of a RUN high phase
      div_ratio = 6'd1; div_load = 1'b1;
      tick();
      div_load = 1'b0;
      tick();
      run = 1'b1;
      push(1, 0, 0, 2'b01, 0); push(1, 1, 1, 2'b01, 0);
      pop_check("pre_reset_run", 2);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs", {27'd0, clock_out, clock_en, state_out, step_ack}, 32'd0);
      check("async_reset_cc", cycle_count, 32'd0);
      run = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      run = 1'b1;
      push(2, 0, 0, 2'b01, 0); push(1, 1, 1, 2'b01, 0); push(1, 1, 0, 2'b01, 0);
      push(1, 0, 0, 2'b01, 0);
      pop_check("post_reset_ratio2", 5);
      run = 1'b0;
      push(1, 0, 0, 2'b00, 0);
      pop_check("post_reset_stop", 1);
      check("cc_after_reset", cycle_count, CC_EN ? 32'd1 : 32'd0);

      check("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
